// File: rtl/exp_range_reduce_pp.sv
// Range-reduction front end for the pipelined 8-bit exp datapath: input FIFO, credit-gated issue, kernel tag line.
// Optional statistics counters are enabled with `define EXP_RR_STATS_EN.
module exp_range_reduce_pp #(
  parameter int DEPTH      = 4,
  parameter int CREDITS    = 4,
  parameter int KERNEL_LAT = 5,
  parameter int THRESH     = 192
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        iValid,
  output logic        oReady,
  input  logic [7:0]  iX,
  input  logic        iCreditRet,
  output logic [7:0]  oKData,
  output logic        oKSign,
  output logic        oTagValid,
  output logic        oTagShift,
  output logic        oCreditErr
`ifdef EXP_RR_STATS_EN
  ,
  output logic [15:0] oIssueCnt,
  output logic [15:0] oStallCnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [3:0]      credits;
  logic [3:0]      credits_next;
  logic            err_set;
  logic            wr_en;
  logic            issue;
  logic [7:0]      rd_x;
  logic            need_shift;
  logic [8:0]      neg_t;
  logic [7:0]      t_mag;
  logic            iss_q;
  logic            shift_q;
  logic [KERNEL_LAT-1:0] tag_v;
  logic [KERNEL_LAT-1:0] tag_s;

  assign oReady = (count != CW'(DEPTH));
  assign wr_en  = iValid && oReady;
  // Issue looks only at the registered count, so a same-cycle write is never bypassed to the kernel.
  assign issue  = (count != '0) && (credits != 4'd0);

  assign rd_x       = mem[rd_ptr];
  assign need_shift = (rd_x >= 8'(THRESH));
  assign neg_t      = 9'd256 - {1'b0, rd_x};
  assign t_mag      = need_shift ? neg_t[7:0] : rd_x;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= iX;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (issue) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, issue})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A return that coincides with an issue cancels out; a return into a full counter is an error.
  always_comb begin
    credits_next = credits;
    err_set      = 1'b0;
    if (issue && !iCreditRet) begin
      credits_next = credits - 4'd1;
    end else if (!issue && iCreditRet) begin
      if (credits == 4'(CREDITS)) begin
        err_set = 1'b1;
      end else begin
        credits_next = credits + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits    <= 4'(CREDITS);
      oCreditErr <= 1'b0;
    end else begin
      credits <= credits_next;
      if (err_set) begin
        oCreditErr <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oKData  <= 8'd0;
      oKSign  <= 1'b0;
      iss_q   <= 1'b0;
      shift_q <= 1'b0;
    end else begin
      oKData  <= issue ? t_mag : 8'd0;
      oKSign  <= issue && need_shift;
      iss_q   <= issue;
      shift_q <= issue && need_shift;
    end
  end

  // Tag line starts one stage behind oKData so its tail lines up with the kernel output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v <= '0;
      tag_s <= '0;
    end else begin
      tag_v <= {tag_v[KERNEL_LAT-2:0], iss_q};
      tag_s <= {tag_s[KERNEL_LAT-2:0], shift_q};
    end
  end

  assign oTagValid = tag_v[KERNEL_LAT-1];
  assign oTagShift = tag_s[KERNEL_LAT-1];

`ifdef EXP_RR_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oIssueCnt <= 16'd0;
      oStallCnt <= 16'd0;
    end else begin
      if (issue && (oIssueCnt != 16'hFFFF)) begin
        oIssueCnt <= oIssueCnt + 16'd1;
      end
      if ((count != '0) && (credits == 4'd0) && (oStallCnt != 16'hFFFF)) begin
        oStallCnt <= oStallCnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_exp_range_reduce_pp.sv
// Self-checking bench for exp_range_reduce_pp: queue-based reference model plus directed literal checks.
module tb_exp_range_reduce_pp;

  localparam int DEPTH      = 4;
  localparam int CREDITS    = 4;
  localparam int KERNEL_LAT = 5;
  localparam int THRESH     = 192;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       iValid = 1'b0;
  logic       oReady;
  logic [7:0] iX = 8'd0;
  logic       iCreditRet = 1'b0;
  logic [7:0] oKData;
  logic       oKSign;
  logic       oTagValid;
  logic       oTagShift;
  logic       oCreditErr;

  int checks = 0;
  int errors = 0;
  int tagPulses = 0;

  exp_range_reduce_pp #(
    .DEPTH(DEPTH), .CREDITS(CREDITS), .KERNEL_LAT(KERNEL_LAT), .THRESH(THRESH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .iValid(iValid), .oReady(oReady), .iX(iX),
    .iCreditRet(iCreditRet), .oKData(oKData), .oKSign(oKSign),
    .oTagValid(oTagValid), .oTagShift(oTagShift), .oCreditErr(oCreditErr)
  );

  always #5 clk = ~clk;

  // Reference model: FIFO contents as a queue, credits as an integer, issues recorded by cycle number.
  int         cyc = 0;
  logic [7:0] mq[$];
  int         mcred = CREDITS;
  bit         merr = 1'b0;
  bit         issued[int];
  logic [7:0] expKd = 8'd0;
  bit         expKs = 1'b0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        issued.delete();
        mcred = CREDITS;
        merr  = 1'b0;
        expKd = 8'd0;
        expKs = 1'b0;
        cyc   = 0;
      end else begin
        bit acc;
        bit iss;
        int x;
        cyc++;
        acc = iValid && (mq.size() < DEPTH);
        iss = (mq.size() > 0) && (mcred > 0);
        expKd = 8'd0;
        expKs = 1'b0;
        if (iss) begin
          x = int'(mq.pop_front());
          expKd = (x < THRESH) ? 8'(x) : 8'(256 - x);
          expKs = (x >= THRESH);
          issued[cyc] = expKs;
        end
        if (acc) mq.push_back(iX);
        if (iCreditRet && !iss && mcred == CREDITS) merr = 1'b1;
        else mcred = mcred + int'(iCreditRet) - int'(iss);
      end
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        bit tv;
        bit ts;
        tv = issued.exists(cyc - KERNEL_LAT);
        ts = tv ? issued[cyc - KERNEL_LAT] : 1'b0;
        if (oTagValid) tagPulses++;
        checkOutput("m_ready", int'(oReady), int'(mq.size() < DEPTH));
        checkOutput("m_kdata", int'(oKData), int'(expKd));
        checkOutput("m_ksign", int'(oKSign), int'(expKs));
        checkOutput("m_tagv", int'(oTagValid), int'(tv));
        checkOutput("m_tags", int'(oTagShift), int'(ts));
        checkOutput("m_err", int'(oCreditErr), int'(merr));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] x);
    iValid = 1'b1;
    iX = x;
    tick();
    iValid = 1'b0;
  endtask

  // Return credits until the model shows an empty FIFO and a full counter, then let the tag line flush.
  task automatic drainAll();
    int n = 0;
    while ((mcred < CREDITS || mq.size() > 0) && n < 200) begin
      iCreditRet = 1'b1;
      tick();
      iCreditRet = 1'b0;
      tick();
      n++;
    end
    if (n >= 200) checkOutput("drain_timeout", n, 0);
    repeat (KERNEL_LAT + 3) tick();
  endtask

  initial begin
    int snap;
    int acc;
    rst_n = 1'b0;
    tick();
    checkOutput("rst_ready", int'(oReady), 1);
    checkOutput("rst_kdata", int'(oKData), 0);
    checkOutput("rst_tagv", int'(oTagValid), 0);
    checkOutput("rst_err", int'(oCreditErr), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single beat of 64: kernel data two edges later, tag five edges after that.
    applyStimulus(8'd64);
    tick();
    checkOutput("t1_kdata", int'(oKData), 64);
    checkOutput("t1_ksign", int'(oKSign), 0);
    repeat (5) tick();
    checkOutput("t1_tagv", int'(oTagValid), 1);
    checkOutput("t1_tags", int'(oTagShift), 0);
    iCreditRet = 1'b1;
    tick();
    iCreditRet = 1'b0;
    drainAll();

    // Values at and above the threshold.
    iValid = 1'b1; iX = 8'd192; tick();
    iX = 8'd255; tick();
    iValid = 1'b0;
    checkOutput("t2_kdata0", int'(oKData), 64);
    checkOutput("t2_ksign0", int'(oKSign), 1);
    tick();
    checkOutput("t2_kdata1", int'(oKData), 1);
    checkOutput("t2_ksign1", int'(oKSign), 1);
    repeat (4) tick();
    checkOutput("t2_tags0", int'(oTagShift), 1);
    tick();
    checkOutput("t2_tags1", int'(oTagShift), 1);
    drainAll();

    // Just below threshold and zero.
    iValid = 1'b1; iX = 8'd191; tick();
    iX = 8'd0; tick();
    iValid = 1'b0;
    checkOutput("t3_kdata0", int'(oKData), 191);
    checkOutput("t3_ksign0", int'(oKSign), 0);
    tick();
    checkOutput("t3_kdata1", int'(oKData), 0);
    repeat (4) tick();
    checkOutput("t3_tagv", int'(oTagValid), 1);
    checkOutput("t3_tags", int'(oTagShift), 0);
    drainAll();

    // Credit starvation: 10 offered beats, 4 issues, FIFO fills.
    snap = tagPulses;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      iValid = 1'b1;
      iX = 8'(10 + i);
      if (oReady) acc++;
      tick();
    end
    iValid = 1'b0;
    repeat (8) tick();
    checkOutput("t4_accepts", acc, CREDITS + DEPTH);
    checkOutput("t4_ready", int'(oReady), 0);
    checkOutput("t4_issues", tagPulses - snap, CREDITS);
    iCreditRet = 1'b1;
    tick();
    iCreditRet = 1'b0;
    repeat (10) tick();
    checkOutput("t4_oneMore", tagPulses - snap, CREDITS + 1);
    drainAll();

    // Issue and return in the same cycle at credits=1, then an over-return.
    snap = tagPulses;
    for (int i = 0; i < 4; i++) begin
      iValid = 1'b1;
      iX = 8'(47 + i);
      tick();
    end
    iValid = 1'b0;
    iCreditRet = 1'b1;
    tick();
    iCreditRet = 1'b0;
    checkOutput("t5_kdata", int'(oKData), 50);
    iValid = 1'b1; iX = 8'd20; tick();
    iX = 8'd21; tick();
    iValid = 1'b0;
    repeat (10) tick();
    checkOutput("t5_issues", tagPulses - snap, 5);
    drainAll();
    checkOutput("t5_errBefore", int'(oCreditErr), 0);
    iCreditRet = 1'b1;
    tick();
    iCreditRet = 1'b0;
    tick();
    checkOutput("t5_errAfter", int'(oCreditErr), 1);

    // Mid-flight reset discards tag-line contents and restores credits.
    iValid = 1'b1; iX = 8'd200; tick();
    iX = 8'd100; tick();
    iX = 8'd30; tick();
    iValid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("t6_ready", int'(oReady), 1);
    checkOutput("t6_err", int'(oCreditErr), 0);
    checkOutput("t6_kdata", int'(oKData), 0);
    snap = tagPulses;
    repeat (10) tick();
    checkOutput("t6_noTags", tagPulses - snap, 0);
    for (int i = 0; i < 5; i++) begin
      iValid = 1'b1;
      iX = 8'(1 + i);
      tick();
    end
    iValid = 1'b0;
    repeat (12) tick();
    checkOutput("t6_issues", tagPulses - snap, CREDITS);
    drainAll();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
